// File: rtl/nway_cache_wb.sv
// nway_cache_wb: N-way set-associative write-back / write-allocate data cache, true-LRU, one word per line.
// Defining CACHE_STATS_EN adds the hit_count / miss_count outputs.
// state  | meaning
// IDLE   | serve hits with zero latency, detect misses
// WB     | write the dirty victim back, wait for mem_valid
// REFILL | fetch the missing word, install it on mem_valid
module nway_cache_wb #(
  parameter int NUM_SETS = 4,
  parameter int NUM_WAYS = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              hit,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = ADDR_W - 2 - SET_W;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(NUM_WAYS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WB     = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;

  logic [1:0]        state;
  logic              valid_q [NUM_SETS][NUM_WAYS];
  logic              dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]  age_q   [NUM_SETS][NUM_WAYS];

  logic [SET_W-1:0]  req_idx, l_idx, acc_idx;
  logic [TAG_W-1:0]  req_tag, l_tag;
  logic [WAY_W-1:0]  hit_way, vic_way, l_way, acc_way;
  logic              l_write, vic_found;
  logic [DATA_W-1:0] l_wdata;
  logic              hit_go, miss_go, refill_done, acc_en;
  logic              unused_addr_bits;

  assign req_idx = req_addr[2 +: SET_W];
  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^req_addr[1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign rdata = data_q[req_idx][hit_way];

  // Fill empty ways first (lowest index), otherwise replace the oldest way.
  always_comb begin
    vic_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!vic_found && !valid_q[req_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = WAY_W'(w);
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[req_idx][w] == AGE_MAX) vic_way = WAY_W'(w);
      end
    end
  end

  assign hit_go      = (state == IDLE) && req_valid && hit;
  assign miss_go     = (state == IDLE) && req_valid && !hit;
  assign refill_done = (state == REFILL) && mem_valid;
  assign stall       = req_valid && !hit_go;
  assign acc_en      = hit_go || refill_done;
  assign acc_idx     = hit_go ? req_idx : l_idx;
  assign acc_way     = hit_go ? hit_way : l_way;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      l_idx     <= '0;
      l_tag     <= '0;
      l_way     <= '0;
      l_write   <= 1'b0;
      l_wdata   <= '0;
    end else begin
      case (state)
        IDLE: if (miss_go) begin
          l_idx   <= req_idx;
          l_tag   <= req_tag;
          l_way   <= vic_way;
          l_write <= req_write;
          l_wdata <= req_wdata;
          if (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) begin
            state     <= WB;
            mem_wr    <= 1'b1;
            mem_addr  <= {tag_q[req_idx][vic_way], req_idx, 2'b00};
            mem_wdata <= data_q[req_idx][vic_way];
          end else begin
            state    <= REFILL;
            mem_rd   <= 1'b1;
            mem_addr <= {req_tag, req_idx, 2'b00};
          end
        end
        WB: if (mem_valid) begin
          state    <= REFILL;
          mem_wr   <= 1'b0;
          mem_rd   <= 1'b1;
          mem_addr <= {l_tag, l_idx, 2'b00};
        end
        REFILL: if (mem_valid) begin
          state  <= IDLE;
          mem_rd <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ages: accessed way becomes 0, every younger way ages by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (hit_go && req_write) dirty_q[req_idx][hit_way] <= 1'b1;
      if (refill_done) begin
        valid_q[l_idx][l_way] <= 1'b1;
        dirty_q[l_idx][l_way] <= l_write;
      end
      if (acc_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == acc_way)
            age_q[acc_idx][w] <= '0;
          else if (age_q[acc_idx][w] < age_q[acc_idx][acc_way])
            age_q[acc_idx][w] <= age_q[acc_idx][w] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit_go && req_write) data_q[req_idx][hit_way] <= req_wdata;
    if (refill_done) begin
      tag_q[l_idx][l_way]  <= l_tag;
      data_q[l_idx][l_way] <= l_write ? l_wdata : mem_rdata;
    end
  end

`ifdef CACHE_STATS_EN
  // The hit that retires a just-refilled request belongs to its miss.
  logic retry_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      retry_q    <= 1'b0;
    end else begin
      retry_q <= refill_done;
      if (hit_go && !retry_q) hit_count <= hit_count + 32'd1;
      if (miss_go) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nway_cache_wb.sv
// Bench for nway_cache_wb: directed scenarios plus random traffic against a recency-list cache model.
// With CACHE_STATS_EN defined the hit/miss counters are checked as well.
module tb_nway_cache_wb;
  localparam int NS = 4;
  localparam int NW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        stall, hit;
  logic [31:0] rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  nway_cache_wb #(.NUM_SETS(NS), .NUM_WAYS(NW), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .hit(hit),
    .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: the responder's copy is written by DUT writebacks, the model keeps its own.
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  // Memory responder: answers 3 cycles after a request appears.
  int          rsp_cnt = 0;
  int          log_rd_n, log_wr_n, both_high;
  logic [31:0] log_rd_addr, log_wr_addr, log_wr_data;

  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    both_high = 0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (mem_rd && mem_wr) both_high++;
      if (rst) rsp_cnt = 0;
      else if (mem_rd || mem_wr) begin
        rsp_cnt++;
        if (rsp_cnt == 3) begin
          mem_valid = 1'b1;
          rsp_cnt = 0;
          if (mem_rd) begin
            mem_rdata = phys_rd(mem_addr);
            log_rd_n++;
            log_rd_addr = mem_addr;
          end else begin
            phys_mem[mem_addr] = mem_wdata;
            log_wr_n++;
            log_wr_addr = mem_addr;
            log_wr_data = mem_wdata;
          end
        end
      end else rsp_cnt = 0;
    end
  end

  // Reference model: per set, lines ordered most- to least-recently used.
  logic [31:0] m_la [NS][NW];
  logic [31:0] m_d  [NS][NW];
  logic        m_dty[NS][NW];
  int          m_n  [NS];

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m_n[s] = 0;
  endtask

  logic        exp_hit, exp_wb;
  logic [31:0] exp_rdata, exp_wb_addr, exp_wb_data, exp_rd_addr;

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    int          s, k;
    logic [31:0] la, td;
    logic        tdy;
    s  = int'(a[3:2]);
    la = {a[31:2], 2'b00};
    k  = -1;
    for (int i = 0; i < m_n[s]; i++) if (m_la[s][i] == la) k = i;
    exp_wb = 1'b0;
    if (k >= 0) begin
      exp_hit   = 1'b1;
      td        = m_d[s][k];
      tdy       = m_dty[s][k];
      exp_rdata = td;
      for (int i = k; i > 0; i--) begin
        m_la[s][i] = m_la[s][i-1]; m_d[s][i] = m_d[s][i-1]; m_dty[s][i] = m_dty[s][i-1];
      end
      m_la[s][0]  = la;
      m_d[s][0]   = w ? d : td;
      m_dty[s][0] = w | tdy;
    end else begin
      exp_hit     = 1'b0;
      exp_rd_addr = la;
      if (m_n[s] == NW) begin
        if (m_dty[s][NW-1]) begin
          exp_wb      = 1'b1;
          exp_wb_addr = m_la[s][NW-1];
          exp_wb_data = m_d[s][NW-1];
          ref_mem[exp_wb_addr] = exp_wb_data;
        end
        m_n[s]--;
      end
      td = w ? d : ref_rd(la);
      exp_rdata = td;
      for (int i = m_n[s]; i > 0; i--) begin
        m_la[s][i] = m_la[s][i-1]; m_d[s][i] = m_d[s][i-1]; m_dty[s][i] = m_dty[s][i-1];
      end
      m_la[s][0] = la; m_d[s][0] = td; m_dty[s][0] = w;
      m_n[s]++;
    end
  endtask

  logic got_first_hit;

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    int cyc;
    model_access(w, a, d);
    log_rd_n = 0;
    log_wr_n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    #1;
    got_first_hit = hit;
    chk($sformatf("hit@%h", a), {31'd0, hit}, {31'd0, exp_hit});
    chk($sformatf("stall@%h", a), {31'd0, stall}, {31'd0, !exp_hit});
    if (!exp_hit) begin
      cyc = 0;
      while (stall && cyc < 40) begin
        @(negedge clk); #1; cyc++;
      end
      chk($sformatf("miss_done@%h", a), {31'd0, stall}, 32'd0);
      chk($sformatf("retry_hit@%h", a), {31'd0, hit}, 32'd1);
      chk($sformatf("wb_n@%h", a), log_wr_n, {31'd0, exp_wb});
      if (exp_wb) begin
        chk($sformatf("wb_addr@%h", a), log_wr_addr, exp_wb_addr);
        chk($sformatf("wb_data@%h", a), log_wr_data, exp_wb_data);
      end
      chk($sformatf("rd_n@%h", a), log_rd_n, 32'd1);
      chk($sformatf("rd_addr@%h", a), log_rd_addr, exp_rd_addr);
    end
    if (!w) chk($sformatf("rdata@%h", a), rdata, exp_rdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (exp_hit) chk($sformatf("hit_no_mem@%h", a), {30'd0, mem_rd, mem_wr}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int cyc;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    phys_mem[32'h4] = 32'hAAAA0001;
    ref_mem[32'h4]  = 32'hAAAA0001;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    // 1: cold load
    do_access(1'b0, 32'h04, 32'h0);
    chk("s1_first_miss", {31'd0, got_first_hit}, 32'd0);
    chk("s1_refill_addr", log_rd_addr, 32'h04);
    chk("s1_rdata", rdata, 32'hAAAA0001);
    chk("s1_no_wb", log_wr_n, 32'd0);

    // 2: LRU in set 0
    do_access(1'b0, 32'h00, 32'h0);
    do_access(1'b0, 32'h10, 32'h0);
    do_access(1'b0, 32'h00, 32'h0);
    chk("s2_rehit", {31'd0, got_first_hit}, 32'd1);
    do_access(1'b0, 32'h20, 32'h0);
    chk("s2_clean_evict_no_wb", log_wr_n, 32'd0);
    do_access(1'b0, 32'h00, 32'h0);
    chk("s2_mru_kept", {31'd0, got_first_hit}, 32'd1);

    // 3: dirty eviction
    do_access(1'b1, 32'h00, 32'hDEADBEEF);
    chk("s3_store_hit", {31'd0, got_first_hit}, 32'd1);
    do_access(1'b0, 32'h10, 32'h0);
    do_access(1'b0, 32'h20, 32'h0);
    chk("s3_wb_taken", log_wr_n, 32'd1);
    chk("s3_wb_addr", log_wr_addr, 32'h00);
    chk("s3_wb_data", log_wr_data, 32'hDEADBEEF);
    chk("s3_refill_addr", log_rd_addr, 32'h20);

    // 4: store miss allocates dirty
    do_access(1'b1, 32'h08, 32'h12345678);
    chk("s4_refill_addr", log_rd_addr, 32'h08);
    do_access(1'b0, 32'h08, 32'h0);
    chk("s4_load_hit", {31'd0, got_first_hit}, 32'd1);
    chk("s4_load_data", rdata, 32'h12345678);
    do_access(1'b0, 32'h18, 32'h0);
    do_access(1'b0, 32'h28, 32'h0);
    chk("s4_dirty_wb_data", log_wr_data, 32'h12345678);

    // 5: reset during refill wait
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0C;
    cyc = 0;
    while (!mem_rd && cyc < 10) begin @(negedge clk); cyc++; end
    chk("s5_mem_rd_seen", {31'd0, mem_rd}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("s5_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
    chk("s5_mem_wr_low", {31'd0, mem_wr}, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_access(1'b0, 32'h0C, 32'h0);
    chk("s5_miss_after_rst", {31'd0, got_first_hit}, 32'd0);
    do_access(1'b0, 32'h04, 32'h0);
    chk("s5_old_line_gone", {31'd0, got_first_hit}, 32'd0);

    // random traffic over 8 tags x 4 sets
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_no_mem", {30'd0, mem_rd, mem_wr}, 32'd0);
      end
      do_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)) << 2, $urandom);
    end
    chk("rd_wr_exclusive", both_high, 32'd0);

`ifdef CACHE_STATS_EN
    do_reset();
    #1;
    chk("s6_rst_hits", hit_count, 32'd0);
    chk("s6_rst_misses", miss_count, 32'd0);
    do_access(1'b0, 32'h00, 32'h0);
    do_access(1'b0, 32'h10, 32'h0);
    do_access(1'b0, 32'h00, 32'h0);
    do_access(1'b0, 32'h20, 32'h0);
    chk("s6_miss_count", miss_count, 32'd3);
    chk("s6_hit_count", hit_count, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end
endmodule
